// File: rtl/tri_raster_scan.sv
// ---------------------------------------------------------------------------
// tri_raster_scan
//
// Takes one triangle, derives its three edge-function coefficients and its
// screen-clipped bounding box, then walks the box one pixel at a time in
// row-major order (y outer, x inner, both ascending). Each sample point is
// sent to an external edge evaluator. The three returned edge values are run
// through the inside test, and covered points leave as fragments over a
// valid/ready handshake. Only one evaluation is ever outstanding.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   tri_valid / tri_ready   triangle handshake (ready only while idle)
//   v0x..v2y                triangle vertices, signed fixed point
//   ef_valid                one-cycle evaluation request
//   ef_v*, ef_px/py, ef_a*, ef_b*
//                           latched vertices, sample point, coefficients;
//                           these stay constant for the whole evaluation
//   ef_done, ef_e1..3       evaluator result pulse and the three edge values
//   frag_valid / frag_ready fragment handshake
//   frag_x/y, frag_w0..2    fragment position and captured edge values
//   tri_done                one-cycle pulse when traversal finishes
// ---------------------------------------------------------------------------
module tri_raster_scan #(
    parameter int FRAC_BITS = 8,
    parameter int SCREEN_W  = 64,
    parameter int SCREEN_H  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    // triangle input
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic signed [15:0] v0x,
    input  logic signed [15:0] v0y,
    input  logic signed [15:0] v1x,
    input  logic signed [15:0] v1y,
    input  logic signed [15:0] v2x,
    input  logic signed [15:0] v2y,
    // edge evaluator request
    output logic               ef_valid,
    output logic signed [15:0] ef_v0x,
    output logic signed [15:0] ef_v0y,
    output logic signed [15:0] ef_v1x,
    output logic signed [15:0] ef_v1y,
    output logic signed [15:0] ef_v2x,
    output logic signed [15:0] ef_v2y,
    output logic signed [15:0] ef_px,
    output logic signed [15:0] ef_py,
    output logic signed [15:0] ef_a1,
    output logic signed [15:0] ef_a2,
    output logic signed [15:0] ef_a3,
    output logic signed [15:0] ef_b1,
    output logic signed [15:0] ef_b2,
    output logic signed [15:0] ef_b3,
    // edge evaluator response
    input  logic               ef_done,
    input  logic signed [31:0] ef_e1,
    input  logic signed [31:0] ef_e2,
    input  logic signed [31:0] ef_e3,
    // fragment output
    output logic               frag_valid,
    input  logic               frag_ready,
    output logic signed [15:0] frag_x,
    output logic signed [15:0] frag_y,
    output logic signed [31:0] frag_w0,
    output logic signed [31:0] frag_w1,
    output logic signed [31:0] frag_w2,
    output logic               tri_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_TEST    = 3'd4;
    localparam logic [2:0] S_EMIT    = 3'd5;
    localparam logic [2:0] S_ADVANCE = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic signed [15:0] STEP       = 16'(1 << FRAC_BITS);
    localparam logic signed [15:0] X_LIM      = 16'((SCREEN_W - 1) << FRAC_BITS);
    localparam logic signed [15:0] Y_LIM      = 16'((SCREEN_H - 1) << FRAC_BITS);
    // Clearing the fraction of a two's complement value rounds toward -inf,
    // so negative minima floor correctly too.
    localparam logic signed [15:0] FLOOR_MASK = ~16'((1 << FRAC_BITS) - 1);

    function automatic logic signed [15:0] smin3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [15:0] smax3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic signed [15:0] clip(input logic signed [15:0] v,
                                                input logic signed [15:0] lim);
        if (v < 16'sd0)
            return 16'sd0;
        else if (v > lim)
            return lim;
        else
            return v;
    endfunction

    logic [2:0]         state;
    logic signed [15:0] xmin, xmax, ymax;
    logic signed [15:0] px, py;

    // Clipped box, derived from the vertices latched in IDLE and
    // registered in SETUP.
    logic signed [15:0] box_xlo, box_xhi, box_ylo, box_yhi;
    logic               box_empty;
    logic signed [15:0] px_next, py_next;
    logic               all_ge, all_le, any_nz, covered;

    always_comb begin
        box_xlo   = clip(smin3(ef_v0x, ef_v1x, ef_v2x) & FLOOR_MASK, X_LIM);
        box_ylo   = clip(smin3(ef_v0y, ef_v1y, ef_v2y) & FLOOR_MASK, Y_LIM);
        box_xhi   = clip(smax3(ef_v0x, ef_v1x, ef_v2x), X_LIM);
        box_yhi   = clip(smax3(ef_v0y, ef_v1y, ef_v2y), Y_LIM);
        box_empty = (box_xlo > box_xhi) || (box_ylo > box_yhi);
    end

    always_comb begin
        px_next = px + STEP;
        py_next = py + STEP;
    end

    // Inside test accepts either winding. Zero counts as inside on both
    // sides so that edge pixels are kept. The all-zero case only arises for
    // degenerate triangles, which must produce nothing.
    always_comb begin
        all_ge  = !frag_w0[31] && !frag_w1[31] && !frag_w2[31];
        all_le  = (frag_w0 <= 32'sd0) && (frag_w1 <= 32'sd0) && (frag_w2 <= 32'sd0);
        any_nz  = |{frag_w0, frag_w1, frag_w2};
        covered = (all_ge || all_le) && any_nz;
    end

    assign tri_ready  = (state == S_IDLE);
    assign ef_valid   = (state == S_ISSUE);
    assign frag_valid = (state == S_EMIT);
    assign tri_done   = (state == S_DONE);
    assign ef_px      = px;
    assign ef_py      = py;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ef_v0x  <= '0;
            ef_v0y  <= '0;
            ef_v1x  <= '0;
            ef_v1y  <= '0;
            ef_v2x  <= '0;
            ef_v2y  <= '0;
            ef_a1   <= '0;
            ef_a2   <= '0;
            ef_a3   <= '0;
            ef_b1   <= '0;
            ef_b2   <= '0;
            ef_b3   <= '0;
            xmin    <= '0;
            xmax    <= '0;
            ymax    <= '0;
            px      <= '0;
            py      <= '0;
            frag_x  <= '0;
            frag_y  <= '0;
            frag_w0 <= '0;
            frag_w1 <= '0;
            frag_w2 <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tri_valid) begin
                        ef_v0x <= v0x;
                        ef_v0y <= v0y;
                        ef_v1x <= v1x;
                        ef_v1y <= v1y;
                        ef_v2x <= v2x;
                        ef_v2y <= v2y;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    ef_a1 <= ef_v1y - ef_v0y;
                    ef_b1 <= ef_v0x - ef_v1x;
                    ef_a2 <= ef_v2y - ef_v1y;
                    ef_b2 <= ef_v1x - ef_v2x;
                    ef_a3 <= ef_v0y - ef_v2y;
                    ef_b3 <= ef_v2x - ef_v0x;
                    xmin  <= box_xlo;
                    xmax  <= box_xhi;
                    ymax  <= box_yhi;
                    px    <= box_xlo;
                    py    <= box_ylo;
                    state <= box_empty ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ef_done) begin
                        frag_w0 <= ef_e1;
                        frag_w1 <= ef_e2;
                        frag_w2 <= ef_e3;
                        state   <= S_TEST;
                    end
                end
                S_TEST: begin
                    if (covered) begin
                        frag_x <= px;
                        frag_y <= py;
                        state  <= S_EMIT;
                    end else begin
                        state  <= S_ADVANCE;
                    end
                end
                S_EMIT: begin
                    // frag_x/y/w only change in TEST/WAIT, so they hold
                    // through any stall here.
                    if (frag_ready)
                        state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (px_next <= xmax) begin
                        px    <= px_next;
                        state <= S_ISSUE;
                    end else if (py_next <= ymax) begin
                        px    <= xmin;
                        py    <= py_next;
                        state <= S_ISSUE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
